eth_frame_builder: RTL and testbench

ETH_FRAME_BUILDER -- requirements
Module: eth_frame_builder

---
 rtl/eth_frame_builder.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_eth_frame_builder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_builder.sv
// eth_frame_builder
// Assembles an Ethernet frame into an internal word buffer and then bursts it
// to the transmit wrapper. The frame is built from a 14-byte header, the
// streamed payload and zero padding up to 46 payload bytes. Bytes are packed
// MSB-first, so the first byte of each word lands in [31:24].
// Optional feature macro: ETH_FRAME_BUILDER_FCS_EN. When it is defined, a
// 4-byte CRC-32 FCS is appended after the pad bytes.
module eth_frame_builder #(
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic        clk_100_mhz,
  input  logic        rst_n,
  input  logic        start,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] eth_type,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        ready_to_send,
  output logic        send,
  output logic        busy,
  output logic        err_overflow
);

  localparam int MIN_PAYLOAD = 46;
  localparam int DEPTH       = (18 + MAX_PAYLOAD + 3) / 4;
  localparam int AW          = $clog2(DEPTH);
  localparam int PW          = $clog2(DEPTH + 2);   // holds 0..DEPTH+1
  localparam int CW          = $clog2(MAX_PAYLOAD + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HDR       = 3'd1,
    PAYLOAD   = 3'd2,
    PAD       = 3'd3,
    FCS       = 3'd4,
    FLUSH     = 3'd5,
    BURST     = 3'd6,
    SEND_WAIT = 3'd7
  } state_t;

`ifdef ETH_FRAME_BUILDER_FCS_EN
  localparam state_t AFTER_DATA = FCS;
`else
  localparam state_t AFTER_DATA = FLUSH;
`endif

  state_t          state_r, state_n;
  logic [111:0]    hdr_sr_r;      // header bytes, shifted out MSB-first
  logic [3:0]      hdr_cnt_r;
  logic [CW-1:0]   byte_cnt_r;    // payload + pad bytes written
  logic            drop_r;        // overflow: swallow bytes until s_last
  logic [23:0]     wacc_r;        // up to three pending bytes of a word
  logic [1:0]      wbyte_r;       // number of pending bytes in wacc_r
  logic [AW-1:0]   wr_addr_r;
  logic [AW-1:0]   rd_addr_r;
  logic [PW-1:0]   word_cnt_r;    // words stored for this frame
  logic [PW-1:0]   burst_cnt_r;   // burst cycle index (2 preamble slots first)
  logic [31:0]     buf_mem [DEPTH];

  logic            s_ready_r, m_valid_r, send_r, busy_r, err_r;
  logic [31:0]     m_data_r;

  logic            wr_en_s;
  logic [7:0]      wr_byte_s;
  logic            err_s;
  logic            send_s;
  logic            mem_we_s;
  logic [31:0]     mem_wdata_s;

  assign s_ready      = s_ready_r;
  assign m_valid      = m_valid_r;
  assign m_data       = m_data_r;
  assign send         = send_r;
  assign busy         = busy_r;
  assign err_overflow = err_r;

`ifdef ETH_FRAME_BUILDER_FCS_EN
  logic [31:0] crc_r;
  logic [1:0]  fcs_cnt_r;
  logic [31:0] fcs_s;
  logic [7:0]  fcs_byte_s;

  // Reflected CRC-32 (poly 0x04C11DB7) advanced by one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ 32'hEDB8_8320;
      else      c = c >> 1;
    end
    return c;
  endfunction

  assign fcs_s = ~crc_r;

  // Select the FCS byte to emit, least significant byte first.
  always_comb begin
    fcs_byte_s = 8'h00;
    case (fcs_cnt_r)
      2'd0:    fcs_byte_s = fcs_s[7:0];
      2'd1:    fcs_byte_s = fcs_s[15:8];
      2'd2:    fcs_byte_s = fcs_s[23:16];
      2'd3:    fcs_byte_s = fcs_s[31:24];
      default: fcs_byte_s = 8'h00;
    endcase
  end

  // CRC over header, payload and pad; it is frozen while the FCS goes out.
  always_ff @(posedge clk_100_mhz or negedge rst_n) begin
    if (!rst_n) begin
      crc_r     <= 32'h0000_0000;
      fcs_cnt_r <= 2'd0;
    end else if ((state_r == IDLE) && start) begin
      crc_r     <= 32'hFFFF_FFFF;
      fcs_cnt_r <= 2'd0;
    end else begin
      if (wr_en_s && (state_r != FCS)) crc_r <= crc32_byte(crc_r, wr_byte_s);
      if (state_r == FCS) fcs_cnt_r <= fcs_cnt_r + 2'd1;
    end
  end
`endif

  // Next-state logic and selection of the byte written this cycle.
  always_comb begin
    state_n   = state_r;
    wr_en_s   = 1'b0;
    wr_byte_s = 8'h00;
    err_s     = 1'b0;
    send_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) state_n = HDR;
        else       state_n = IDLE;
      end
      HDR: begin
        wr_en_s   = 1'b1;
        wr_byte_s = hdr_sr_r[111:104];
        if (hdr_cnt_r == 4'd13) state_n = PAYLOAD;
        else                    state_n = HDR;
      end
      PAYLOAD: begin
        if (s_valid && s_ready_r) begin
          if (drop_r) begin
            if (s_last) state_n = IDLE;
            else        state_n = PAYLOAD;
          end else begin
            wr_en_s   = 1'b1;
            wr_byte_s = s_data;
            if (s_last) begin
              if (byte_cnt_r < CW'(MIN_PAYLOAD - 1)) state_n = PAD;
              else                                    state_n = AFTER_DATA;
            end else if (byte_cnt_r == CW'(MAX_PAYLOAD - 1)) begin
              err_s   = 1'b1;
              state_n = PAYLOAD;
            end else begin
              state_n = PAYLOAD;
            end
          end
        end else begin
          state_n = PAYLOAD;
        end
      end
      PAD: begin
        wr_en_s   = 1'b1;
        wr_byte_s = 8'h00;
        if (byte_cnt_r == CW'(MIN_PAYLOAD - 1)) state_n = AFTER_DATA;
        else                                     state_n = PAD;
      end
`ifdef ETH_FRAME_BUILDER_FCS_EN
      FCS: begin
        wr_en_s   = 1'b1;
        wr_byte_s = fcs_byte_s;
        if (fcs_cnt_r == 2'd3) state_n = FLUSH;
        else                   state_n = FCS;
      end
`endif
      FLUSH: begin
        state_n = BURST;
      end
      BURST: begin
        if (burst_cnt_r == (word_cnt_r + PW'(1))) state_n = SEND_WAIT;
        else                                      state_n = BURST;
      end
      SEND_WAIT: begin
        if (ready_to_send) begin
          send_s  = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = SEND_WAIT;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Buffer write: a completed word, or the zero-filled partial word in FLUSH.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_wdata_s = 32'h0000_0000;
    if (wr_en_s && (wbyte_r == 2'd3)) begin
      mem_we_s    = 1'b1;
      mem_wdata_s = {wacc_r, wr_byte_s};
    end else if ((state_r == FLUSH) && (wbyte_r != 2'd0)) begin
      mem_we_s = 1'b1;
      case (wbyte_r)
        2'd1:    mem_wdata_s = {wacc_r[7:0], 24'h000000};
        2'd2:    mem_wdata_s = {wacc_r[15:0], 16'h0000};
        2'd3:    mem_wdata_s = {wacc_r[23:0], 8'h00};
        default: mem_wdata_s = 32'h0000_0000;
      endcase
    end else begin
      mem_we_s    = 1'b0;
      mem_wdata_s = 32'h0000_0000;
    end
  end

  // State register.
  always_ff @(posedge clk_100_mhz or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_n;
  end

  // Frame assembly: header shifter, byte/word counters, packing, burst pointers.
  always_ff @(posedge clk_100_mhz or negedge rst_n) begin
    if (!rst_n) begin
      hdr_sr_r    <= 112'h0;
      hdr_cnt_r   <= 4'd0;
      byte_cnt_r  <= '0;
      drop_r      <= 1'b0;
      wacc_r      <= 24'h000000;
      wbyte_r     <= 2'd0;
      wr_addr_r   <= '0;
      rd_addr_r   <= '0;
      word_cnt_r  <= '0;
      burst_cnt_r <= '0;
    end else if ((state_r == IDLE) && start) begin
      hdr_sr_r    <= {dst_mac, src_mac, eth_type};
      hdr_cnt_r   <= 4'd0;
      byte_cnt_r  <= '0;
      drop_r      <= 1'b0;
      wacc_r      <= 24'h000000;
      wbyte_r     <= 2'd0;
      wr_addr_r   <= '0;
      word_cnt_r  <= '0;
    end else begin
      if (state_r == HDR) begin
        hdr_sr_r  <= {hdr_sr_r[103:0], 8'h00};
        hdr_cnt_r <= hdr_cnt_r + 4'd1;
      end
      if (err_s) drop_r <= 1'b1;
      if (wr_en_s && ((state_r == PAYLOAD) || (state_r == PAD)))
        byte_cnt_r <= byte_cnt_r + CW'(1);
      if (wr_en_s) begin
        wacc_r  <= {wacc_r[15:0], wr_byte_s};
        wbyte_r <= wbyte_r + 2'd1;
      end
      if (mem_we_s) begin
        wr_addr_r  <= wr_addr_r + AW'(1);
        word_cnt_r <= word_cnt_r + PW'(1);
      end
      if (state_r == FLUSH) begin
        burst_cnt_r <= '0;
        rd_addr_r   <= '0;
      end else if (state_r == BURST) begin
        burst_cnt_r <= burst_cnt_r + PW'(1);
        if (burst_cnt_r >= PW'(2)) rd_addr_r <= rd_addr_r + AW'(1);
      end
    end
  end

  // Frame buffer storage; contents survive reset on purpose.
  always_ff @(posedge clk_100_mhz) begin
    if (mem_we_s) buf_mem[wr_addr_r] <= mem_wdata_s;
  end

  // Registered outputs; m_valid trails the BURST state by one cycle.
  always_ff @(posedge clk_100_mhz or negedge rst_n) begin
    if (!rst_n) begin
      s_ready_r <= 1'b0;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
      send_r    <= 1'b0;
      m_valid_r <= 1'b0;
      m_data_r  <= 32'h0000_0000;
    end else begin
      s_ready_r <= (state_n == PAYLOAD);
      busy_r    <= (state_n != IDLE);
      err_r     <= err_s;
      send_r    <= send_s;
      if (state_r == BURST) begin
        m_valid_r <= 1'b1;
        if (burst_cnt_r >= PW'(2)) m_data_r <= buf_mem[rd_addr_r];
        else                       m_data_r <= 32'h0000_0000;
      end else begin
        m_valid_r <= 1'b0;
        m_data_r  <= 32'h0000_0000;
      end
    end
  end

endmodule

// File: tb/tb_eth_frame_builder.sv
// Directed self-checking bench for eth_frame_builder (MAX_PAYLOAD = 1500).
// Follows ETH_FRAME_BUILDER_FCS_EN: with it defined the expected frames carry
// a 4-byte FCS, without it they end after the pad.
`timescale 1ns/1ps
module tb_eth_frame_builder;

`ifdef ETH_FRAME_BUILDER_FCS_EN
  localparam int FCS_LEN = 4;
`else
  localparam int FCS_LEN = 0;
`endif

  logic        clk_100_mhz = 1'b0;
  logic        rst_n;
  logic        start;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [15:0] eth_type;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        ready_to_send;
  logic        send;
  logic        busy;
  logic        err_overflow;

  eth_frame_builder #(.MAX_PAYLOAD(1500)) dut (
    .clk_100_mhz   (clk_100_mhz),
    .rst_n         (rst_n),
    .start         (start),
    .dst_mac       (dst_mac),
    .src_mac       (src_mac),
    .eth_type      (eth_type),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .ready_to_send (ready_to_send),
    .send          (send),
    .busy          (busy),
    .err_overflow  (err_overflow)
  );

  // 100 MHz clock.
  always #5 clk_100_mhz = ~clk_100_mhz;

  int checks = 0;
  int failures = 0;

  logic [31:0] cap_q [$];
  int          runs = 0;
  int          send_cnt = 0;
  int          err_cnt = 0;
  int          zero_viol = 0;
  logic        prev_valid = 1'b0;

  logic [7:0]  pay [0:1599];
  logic [7:0]  exp_b [$];
  logic [31:0] exp_w [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk_100_mhz) begin
    if (m_valid) begin
      cap_q.push_back(m_data);
      if (!prev_valid) runs++;
    end else if (m_data != 32'h0) begin
      zero_viol++;
    end
    if (send) send_cnt++;
    if (err_overflow) err_cnt++;
    prev_valid = m_valid;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_100_mhz);
      #1;
    end
  endtask

  task automatic clear_mon();
    cap_q.delete();
    runs = 0;
    send_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic feed(input int n);
    int tmo;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = pay[i];
      s_last  = (i == n - 1);
      tmo = 0;
      while (!s_ready && tmo < 100) begin
        tick(1);
        tmo++;
      end
      if (tmo >= 100) begin
        check_val("s_ready_timeout", {31'b0, s_ready}, 32'd1);
        break;
      end
      tick(1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int t;
    t = 0;
    while (busy && t < limit) begin
      tick(1);
      t++;
    end
    check_val(tag, {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_valid(input string tag, input logic level, input int limit);
    int t;
    t = 0;
    while ((m_valid !== level) && t < limit) begin
      tick(1);
      t++;
    end
    check_val(tag, {31'b0, m_valid}, {31'b0, level});
  endtask

`ifdef ETH_FRAME_BUILDER_FCS_EN
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] x;
    x = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      if (x[0]) x = (x >> 1) ^ 32'hEDB8_8320;
      else      x = x >> 1;
    end
    return x;
  endfunction

  // CRC over the 64 received frame bytes must leave the well-known residue.
  task automatic residue_check(input string tag);
    logic [31:0] c;
    logic [31:0] w;
    logic [31:0] rev;
    c = 32'hFFFF_FFFF;
    for (int i = 2; i < 18; i++) begin
      w = (i < cap_q.size()) ? cap_q[i] : 32'h0;
      c = crc_upd(c, w[31:24]);
      c = crc_upd(c, w[23:16]);
      c = crc_upd(c, w[15:8]);
      c = crc_upd(c, w[7:0]);
    end
    for (int k = 0; k < 32; k++) rev[k] = c[31 - k];
    check_val(tag, rev, 32'hC704_DD7B);
  endtask
`endif

  task automatic build_exp(input int n);
    int          len;
    logic [31:0] word;
    logic [31:0] c;
    exp_b.delete();
    exp_w.delete();
    for (int i = 0; i < 6; i++) exp_b.push_back(dst_mac[47 - 8*i -: 8]);
    for (int i = 0; i < 6; i++) exp_b.push_back(src_mac[47 - 8*i -: 8]);
    exp_b.push_back(eth_type[15:8]);
    exp_b.push_back(eth_type[7:0]);
    for (int i = 0; i < n; i++) exp_b.push_back(pay[i]);
    while (exp_b.size() < 60) exp_b.push_back(8'h00);
    c = 32'hFFFF_FFFF;
`ifdef ETH_FRAME_BUILDER_FCS_EN
    foreach (exp_b[i]) c = crc_upd(c, exp_b[i]);
    c = ~c;
    exp_b.push_back(c[7:0]);
    exp_b.push_back(c[15:8]);
    exp_b.push_back(c[23:16]);
    exp_b.push_back(c[31:24]);
`endif
    len = exp_b.size();
    for (int w = 0; w < (len + 3) / 4; w++) begin
      word = 32'h0;
      for (int k = 0; k < 4; k++)
        word = {word[23:0], ((4*w + k) < len) ? exp_b[4*w + k] : 8'h00};
      exp_w.push_back(word);
    end
  endtask

  task automatic check_frame(input string tag, input int n, input int hand_w);
    build_exp(n);
    check_val({tag, "_valid_cycles"}, cap_q.size(), hand_w + 2);
    check_val({tag, "_runs"}, runs, 32'd1);
    if (cap_q.size() >= 2) begin
      check_val({tag, "_pre0"}, cap_q[0], 32'h0);
      check_val({tag, "_pre1"}, cap_q[1], 32'h0);
    end
    for (int i = 0; i < exp_w.size(); i++) begin
      if (i + 2 < cap_q.size())
        check_val($sformatf("%s_w%0d", tag, i), cap_q[i + 2], exp_w[i]);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    s_valid       = 1'b0;
    s_last        = 1'b0;
    s_data        = 8'h00;
    ready_to_send = 1'b1;
    dst_mac       = 48'h0102_0304_0506;
    src_mac       = 48'h1112_1314_1516;
    eth_type      = 16'h0800;
    tick(3);

    check_val("rst_s_ready", {31'b0, s_ready}, 32'd0);
    check_val("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check_val("rst_m_data", m_data, 32'h0);
    check_val("rst_send", {31'b0, send}, 32'd0);
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_err", {31'b0, err_overflow}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // 46-byte payload 0x00..0x2D: minimum frame, no pad.
    for (int i = 0; i < 46; i++) pay[i] = 8'(i);
    clear_mon();
    feed(46);
    wait_idle("n46_idle", 3000);
    tick(2);
    check_frame("n46", 46, (FCS_LEN != 0) ? 16 : 15);
    if (cap_q.size() > 2) check_val("n46_word0", cap_q[2], 32'h0102_0304);
    check_val("n46_send", send_cnt, 32'd1);
    check_val("n46_err", err_cnt, 32'd0);
`ifdef ETH_FRAME_BUILDER_FCS_EN
    residue_check("n46_residue");
`endif

    // Single byte 0xAB: 45 pad bytes follow.
    pay[0] = 8'hAB;
    clear_mon();
    feed(1);
    wait_idle("n1_idle", 3000);
    tick(2);
    check_frame("n1", 1, (FCS_LEN != 0) ? 16 : 15);
    if (cap_q.size() > 5) check_val("n1_word3", cap_q[5], 32'h0800_AB00);
    check_val("n1_send", send_cnt, 32'd1);

    // 47 bytes: partial last word.
    for (int i = 0; i < 47; i++) pay[i] = 8'hFF - 8'(i);
    clear_mon();
    feed(47);
    wait_idle("n47_idle", 3000);
    tick(2);
    check_frame("n47", 47, (FCS_LEN != 0) ? 17 : 16);

    // Exactly MAX_PAYLOAD bytes with s_last on the last one: legal.
    for (int i = 0; i < 1501; i++) pay[i] = 8'(i * 7 + 3);
    clear_mon();
    feed(1500);
    wait_idle("n1500_idle", 5000);
    tick(2);
    check_frame("n1500", 1500, (FCS_LEN != 0) ? 380 : 379);
    check_val("n1500_err", err_cnt, 32'd0);
    check_val("n1500_send", send_cnt, 32'd1);

    // 1501 bytes: overflow, drop through s_last, no burst.
    clear_mon();
    feed(1501);
    check_val("ovf_busy", {31'b0, busy}, 32'd0);
    tick(30);
    check_val("ovf_err_pulses", err_cnt, 32'd1);
    check_val("ovf_no_valid", cap_q.size(), 32'd0);
    check_val("ovf_no_send", send_cnt, 32'd0);

    // ready_to_send held low after the burst; start during BURST ignored.
    ready_to_send = 1'b0;
    for (int i = 0; i < 46; i++) pay[i] = 8'(i) ^ 8'h5A;
    clear_mon();
    feed(46);
    wait_valid("rts_valid_rise", 1'b1, 200);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_valid("rts_valid_fall", 1'b0, 100);
    tick(10);
    check_val("rts_low_no_send", send_cnt, 32'd0);
    check_val("rts_low_busy", {31'b0, busy}, 32'd1);
    ready_to_send = 1'b1;
    tick(1);
    check_val("send_pulse", {31'b0, send}, 32'd1);
    tick(1);
    check_val("send_width", {31'b0, send}, 32'd0);
    tick(40);
    check_val("rts_send_count", send_cnt, 32'd1);
    check_val("rts_busy_after", {31'b0, busy}, 32'd0);
    check_frame("rts", 46, (FCS_LEN != 0) ? 16 : 15);

    // Reset in the middle of a burst, then a clean frame.
    for (int i = 0; i < 46; i++) pay[i] = 8'(i);
    clear_mon();
    feed(46);
    wait_valid("rstb_valid_rise", 1'b1, 200);
    tick(3);
    rst_n = 1'b0;
    #1;
    check_val("rstb_m_valid", {31'b0, m_valid}, 32'd0);
    check_val("rstb_m_data", m_data, 32'h0);
    check_val("rstb_busy", {31'b0, busy}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check_val("rstb_no_send", send_cnt, 32'd0);
    clear_mon();
    feed(46);
    wait_idle("after_rst_idle", 3000);
    tick(2);
    check_frame("after_rst", 46, (FCS_LEN != 0) ? 16 : 15);
    check_val("after_rst_send", send_cnt, 32'd1);
`ifdef ETH_FRAME_BUILDER_FCS_EN
    residue_check("after_rst_residue");
`endif

    check_val("m_data_zero_when_idle", zero_viol, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
